dose_alarm_sequencer: RTL and testbench
=======================================

Name: dose_alarm_sequencer

Overview:
- Sits directly downstream of the next-pill monitor and upstream of the RAM dose log and LED/LCD outputs.
- Converts per-pill "due" indications into an alert sequence: LED, buzzer pattern and a grace window.
- Each alert is either acknowledged by the shaped "taken" button or logged as a missed dose through a valid/ready record to the RAM writer.
- Keeps saturating per-pill miss counters for the LCD missed scene.

Parameters:
NUM_PILLS, 3, number of tracked pills (2..4)
GRACE_SECONDS, 60, seconds an alert waits for acknowledge before being logged as missed (1..255)
CNT_W, 4, width of each per-pill miss counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
secTick  in  1  one-cycle pulse per elapsed second (demo or real rate, from clock block)
pillDue  in  NUM_PILLS  level per pill, high while that pill's countdown is zero
takenPulse  in  1  one-cycle shaped "pill taken" button pulse
timeBCD  in  24  current HH:MM:SS BCD time
alarmLED  out  NUM_PILLS  one-hot LED of the pill currently alerting
buzzer  out  1  alert tone enable
missValid  out  1  missed-dose record valid
missPillId  out  2  pill index of the record
missTime  out  24  BCD time the alert started
missReady  in  1  RAM writer accepts the record
missCounts  out  NUM_PILLS*CNT_W  packed saturating miss counters, pill 0 in LSBs
seqState  out  2  IDLE=0, ALERT=1, LOG=2

Behaviour:
- Reset (async on rst_n low, released synchronously):
  - seqState=IDLE; alarmLED=0, buzzer=0, missValid=0, missPillId=0, missTime=0, missCounts=0.
  - pending register=0, grace counter=0, pillDue history=0.
- All outputs are registered.
- Due capture, every state:
  - A rising edge on pillDue[i] (registered compare) sets pending[i].
  - A rising edge on a pill that is already pending, or on the pill currently alerting, is absorbed; no second alert is raised.
- IDLE:
  - If pending != 0, select the lowest-index pending pill as curId.
  - Latch timeBCD into missTime and load grace=GRACE_SECONDS.
  - Next cycle: seqState=ALERT, alarmLED=onehot(curId), buzzer=1.
  - takenPulse in IDLE is ignored.
- ALERT:
  - buzzer toggles on every secTick (1 Hz pattern starting high); alarmLED is held.
  - On secTick, grace decrements.
  - takenPulse: clear pending[curId]. Next cycle: IDLE, alarmLED=0, buzzer=0, no counter change.
  - When grace reaches 0 on a secTick: next cycle seqState=LOG, alarmLED=0, buzzer=0, missValid=1, missPillId=curId.
  - takenPulse in the same cycle as grace expiry: taken wins, no log.
- LOG:
  - missValid is held high and missPillId/missTime are stable until missReady is high with missValid high.
  - On that handshake cycle:
    - missCounts[curId] increments, saturating at 2^CNT_W-1.
    - pending[curId] clears.
    - Next cycle: missValid=0, seqState=IDLE.
  - takenPulse in LOG is ignored; the miss stands.
  - secTick has no effect in LOG.
- Latency:
  - pending to ALERT: 2 cycles from the pillDue edge.
  - ALERT to idle after takenPulse: 1 cycle.
  - Back-to-back pending pills: the next alert starts 1 cycle after returning to IDLE.
- Reset mid-operation: immediate return to the reset values above; pending alerts and the partial record are discarded, counters are cleared.
- missPillId is zero-extended when NUM_PILLS < 4.

Optional Feature:
- Macro: DOSE_ALARM_SNOOZE_EN.
- When defined:
  - Adds input snoozePulse (1 bit).
  - In ALERT, the first snoozePulse reloads grace to GRACE_SECONDS and forces buzzer=0 for the remainder of that alert (LED stays on).
  - Further snoozes in the same alert are ignored.
  - The snooze allowance clears on leaving ALERT.
  - takenPulse beats snoozePulse when both arrive in the same cycle.
- When undefined: no snoozePulse port, and behaviour is exactly as above.

Test Plan:
- Bench parameters: GRACE_SECONDS=3, NUM_PILLS=3, secTick every 10 cycles.
- Reset then idle: with pillDue=0 for 100 cycles -> seqState=0, all outputs 0, missCounts=0.
- Acknowledged dose: pillDue[1] rises, takenPulse 5 cycles after ALERT entry -> alarmLED=3'b010 for those cycles, then 0; seqState back to 0; missCounts unchanged; missValid never high.
- Missed dose with backpressure:
  - Stimulus: pillDue[0] rises at timeBCD=24'h081500; no taken; missReady held low 4 cycles in LOG, then high.
  - Response: missValid high with missPillId=0 and missTime=24'h081500, both stable across the stall; missCounts[3:0]=1 after the handshake.
- Simultaneous due: pillDue[2] and pillDue[0] rise in the same cycle; both alerts are missed and logged -> records arrive in order pill 0 then pill 2, and each of those counters equals 1.
- Saturation and edge cases:
  - 16 logged misses of pill 1 -> missCounts[7:4]=4'hF.
  - takenPulse coincident with the grace-expiry secTick -> no record, counter unchanged.
- Reset mid-LOG: rst_n pulsed low while missValid=1 -> missValid=0 immediately, counters=0, seqState=0; the pending alert is not re-raised.

Source files
------------

// File: rtl/dose_alarm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dose_alarm_sequencer
// Brief    : Turns per-pill due levels into LED/buzzer alerts with a grace
//            window; unacknowledged alerts become missed-dose log records.
//            Optional DOSE_ALARM_SNOOZE_EN adds a one-shot snooze input.
// Revision : 1.0 - initial release
// ============================================================================
module dose_alarm_sequencer #(
  parameter int NUM_PILLS     = 3,
  parameter int GRACE_SECONDS = 60,
  parameter int CNT_W         = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       secTick,
  input  logic [NUM_PILLS-1:0]       pillDue,
  input  logic                       takenPulse,
`ifdef DOSE_ALARM_SNOOZE_EN
  input  logic                       snoozePulse,
`endif
  input  logic [23:0]                timeBCD,
  output logic [NUM_PILLS-1:0]       alarmLED,
  output logic                       buzzer,
  output logic                       missValid,
  output logic [1:0]                 missPillId,
  output logic [23:0]                missTime,
  input  logic                       missReady,
  output logic [NUM_PILLS*CNT_W-1:0] missCounts,
  output logic [1:0]                 seqState
);

  localparam logic [7:0]           c_GRACE = 8'(GRACE_SECONDS);
  localparam logic [NUM_PILLS-1:0] c_ONE   = NUM_PILLS'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALERT = 2'd1,
    LOG   = 2'd2
  } state_t;

  state_t               r_state, w_stateNext;
  logic [NUM_PILLS-1:0] r_pending, w_pendingNext;
  logic [NUM_PILLS-1:0] r_dueHist, w_dueRise;
  logic [NUM_PILLS-1:0] w_curOneHot, w_activeMask, w_clrMask, w_cntInc;
  logic [1:0]           r_curId, w_curIdNext, w_lowestId;
  logic [7:0]           r_grace, w_graceNext;
  logic [NUM_PILLS-1:0] r_led, w_ledNext;
  logic                 r_buzzer, w_buzzerNext;
  logic                 r_missValid, w_missValidNext;
  logic [1:0]           r_missId, w_missIdNext;
  logic [23:0]          r_missTime, w_missTimeNext;
  logic                 r_snoozed, w_snoozedNext;
  logic                 w_snoozeReq;

`ifdef DOSE_ALARM_SNOOZE_EN
  assign w_snoozeReq = snoozePulse;
`else
  assign w_snoozeReq = 1'b0;
`endif

  assign w_dueRise    = pillDue & ~r_dueHist;
  assign w_curOneHot  = c_ONE << r_curId;
  // Re-asserting the pill being serviced must not queue a duplicate alert.
  assign w_activeMask = (r_state != IDLE) ? w_curOneHot : '0;

  always_comb begin
    w_lowestId = 2'd0;
    for (int i = NUM_PILLS - 1; i >= 0; i--) begin
      if (r_pending[i]) w_lowestId = 2'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_dueHist   <= '0;
      r_curId     <= 2'd0;
      r_grace     <= 8'd0;
      r_led       <= '0;
      r_buzzer    <= 1'b0;
      r_missValid <= 1'b0;
      r_missId    <= 2'd0;
      r_missTime  <= 24'd0;
      r_snoozed   <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_pending   <= w_pendingNext;
      r_dueHist   <= pillDue;
      r_curId     <= w_curIdNext;
      r_grace     <= w_graceNext;
      r_led       <= w_ledNext;
      r_buzzer    <= w_buzzerNext;
      r_missValid <= w_missValidNext;
      r_missId    <= w_missIdNext;
      r_missTime  <= w_missTimeNext;
      r_snoozed   <= w_snoozedNext;
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_curIdNext     = r_curId;
    w_graceNext     = r_grace;
    w_ledNext       = r_led;
    w_buzzerNext    = r_buzzer;
    w_missValidNext = r_missValid;
    w_missIdNext    = r_missId;
    w_missTimeNext  = r_missTime;
    w_snoozedNext   = r_snoozed;
    w_clrMask       = '0;
    w_cntInc        = '0;

    case (r_state)
      IDLE: begin
        w_snoozedNext = 1'b0;
        if (|r_pending) begin
          w_curIdNext    = w_lowestId;
          w_missTimeNext = timeBCD;
          w_graceNext    = c_GRACE;
          w_stateNext    = ALERT;
          w_ledNext      = c_ONE << w_lowestId;
          w_buzzerNext   = 1'b1;
        end
      end
      ALERT: begin
        // Acknowledge outranks both snooze and a coincident grace expiry.
        if (takenPulse) begin
          w_clrMask     = w_curOneHot;
          w_stateNext   = IDLE;
          w_ledNext     = '0;
          w_buzzerNext  = 1'b0;
          w_snoozedNext = 1'b0;
        end else if (w_snoozeReq && !r_snoozed) begin
          w_graceNext   = c_GRACE;
          w_buzzerNext  = 1'b0;
          w_snoozedNext = 1'b1;
        end else if (secTick) begin
          if (r_grace <= 8'd1) begin
            w_graceNext     = 8'd0;
            w_stateNext     = LOG;
            w_ledNext       = '0;
            w_buzzerNext    = 1'b0;
            w_missValidNext = 1'b1;
            w_missIdNext    = r_curId;
            w_snoozedNext   = 1'b0;
          end else begin
            w_graceNext = r_grace - 8'd1;
            if (!r_snoozed) w_buzzerNext = ~r_buzzer;
          end
        end
      end
      LOG: begin
        if (missReady) begin
          w_cntInc        = w_curOneHot;
          w_clrMask       = w_curOneHot;
          w_missValidNext = 1'b0;
          w_stateNext     = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase

    w_pendingNext = (r_pending & ~w_clrMask) | (w_dueRise & ~w_activeMask);
  end

  generate
    for (genvar g = 0; g < NUM_PILLS; g++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (w_cntInc[g] && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign missCounts[g*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate

  assign alarmLED   = r_led;
  assign buzzer     = r_buzzer;
  assign missValid  = r_missValid;
  assign missPillId = r_missId;
  assign missTime   = r_missTime;
  assign seqState   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dose_alarm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dose_alarm_sequencer
// Brief    : Directed vector table plus hand sequences for the dose alarm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dose_alarm_sequencer;

  localparam int NP = 3;
  localparam int GR = 3;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            secTick = 1'b0;
  logic [NP-1:0]   pillDue = '0;
  logic            takenPulse = 1'b0;
  logic [23:0]     timeBCD = 24'd0;
  logic            missReady = 1'b0;
  logic [NP-1:0]   alarmLED;
  logic            buzzer;
  logic            missValid;
  logic [1:0]      missPillId;
  logic [23:0]     missTime;
  logic [NP*CW-1:0] missCounts;
  logic [1:0]      seqState;

  dose_alarm_sequencer #(.NUM_PILLS(NP), .GRACE_SECONDS(GR), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .secTick(secTick), .pillDue(pillDue),
    .takenPulse(takenPulse), .timeBCD(timeBCD), .alarmLED(alarmLED),
    .buzzer(buzzer), .missValid(missValid), .missPillId(missPillId),
    .missTime(missTime), .missReady(missReady), .missCounts(missCounts),
    .seqState(seqState)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nBad = 0;
  bit autoTick = 1'b0;
  int tickCnt = 0;

  typedef struct {
    logic [2:0]  due;
    logic        taken, tick, ready;
    logic [1:0]  st;
    logic [2:0]  led;
    logic        buz, mv;
    logic [1:0]  id;
    logic [23:0] tm;
    logic [11:0] cnt;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic [2:0] due, logic taken, logic tick, logic ready,
                              logic [1:0] st, logic [2:0] led, logic buz, logic mv,
                              logic [1:0] id, logic [23:0] tm, logic [11:0] cnt);
    vec_t v;
    v.due = due; v.taken = taken; v.tick = tick; v.ready = ready;
    v.st = st; v.led = led; v.buz = buz; v.mv = mv; v.id = id; v.tm = tm; v.cnt = cnt;
    return v;
  endfunction

  // Advance one clock; inputs and samples live 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (autoTick) begin
      secTick = (tickCnt == 9);
      tickCnt = (tickCnt + 1) % 10;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic waitValid(input string name);
    for (int k = 0; k < 200 && !missValid; k++) cyc();
    check(name, 64'(missValid), 64'd1);
  endtask

  initial begin
    logic [1:0] ids[2];
    int  nRec;
    int  nTick;
    bit  bad;

    // Reset and quiet idle.
    cyc();
    check("reset_state", {missCounts, seqState, alarmLED, buzzer, missValid, missPillId, missTime},
          64'd0);
    cyc();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if ({missCounts, seqState, alarmLED, buzzer, missValid, missPillId, missTime} != '0)
        bad = 1'b1;
    end
    check("idle_100", 64'(bad), 64'd0);

    // Acknowledged pill 1, then a manually ticked miss of pill 2.
    timeBCD = 24'h120000;
    tbl[0]  = mk(3'b000, 0, 0, 0, 2'd0, 3'b000, 0, 0, 2'd0, 24'h000000, 12'h000);
    tbl[1]  = mk(3'b010, 0, 0, 0, 2'd0, 3'b000, 0, 0, 2'd0, 24'h000000, 12'h000);
    tbl[2]  = mk(3'b010, 0, 0, 0, 2'd1, 3'b010, 1, 0, 2'd0, 24'h120000, 12'h000);
    tbl[3]  = mk(3'b010, 0, 0, 0, 2'd1, 3'b010, 1, 0, 2'd0, 24'h120000, 12'h000);
    tbl[4]  = mk(3'b010, 0, 0, 0, 2'd1, 3'b010, 1, 0, 2'd0, 24'h120000, 12'h000);
    tbl[5]  = mk(3'b010, 0, 0, 0, 2'd1, 3'b010, 1, 0, 2'd0, 24'h120000, 12'h000);
    tbl[6]  = mk(3'b010, 0, 0, 0, 2'd1, 3'b010, 1, 0, 2'd0, 24'h120000, 12'h000);
    tbl[7]  = mk(3'b010, 1, 0, 0, 2'd0, 3'b000, 0, 0, 2'd0, 24'h120000, 12'h000);
    tbl[8]  = mk(3'b010, 1, 0, 0, 2'd0, 3'b000, 0, 0, 2'd0, 24'h120000, 12'h000);
    tbl[9]  = mk(3'b000, 0, 0, 0, 2'd0, 3'b000, 0, 0, 2'd0, 24'h120000, 12'h000);
    tbl[10] = mk(3'b100, 0, 0, 0, 2'd0, 3'b000, 0, 0, 2'd0, 24'h120000, 12'h000);
    tbl[11] = mk(3'b100, 0, 0, 0, 2'd1, 3'b100, 1, 0, 2'd0, 24'h120000, 12'h000);
    tbl[12] = mk(3'b100, 0, 1, 0, 2'd1, 3'b100, 0, 0, 2'd0, 24'h120000, 12'h000);
    tbl[13] = mk(3'b100, 0, 0, 0, 2'd1, 3'b100, 0, 0, 2'd0, 24'h120000, 12'h000);
    tbl[14] = mk(3'b100, 0, 1, 0, 2'd1, 3'b100, 1, 0, 2'd0, 24'h120000, 12'h000);
    tbl[15] = mk(3'b100, 0, 1, 0, 2'd2, 3'b000, 0, 1, 2'd2, 24'h120000, 12'h000);
    tbl[16] = mk(3'b100, 1, 1, 0, 2'd2, 3'b000, 0, 1, 2'd2, 24'h120000, 12'h000);
    tbl[17] = mk(3'b100, 0, 0, 1, 2'd0, 3'b000, 0, 0, 2'd2, 24'h120000, 12'h100);
    tbl[18] = mk(3'b000, 0, 0, 0, 2'd0, 3'b000, 0, 0, 2'd2, 24'h120000, 12'h100);
    for (int i = 0; i < 19; i++) begin
      pillDue = tbl[i].due; takenPulse = tbl[i].taken;
      secTick = tbl[i].tick; missReady = tbl[i].ready;
      cyc();
      check($sformatf("vec%0d", i),
            64'({seqState, alarmLED, buzzer, missValid, missPillId, missTime, missCounts}),
            64'({tbl[i].st, tbl[i].led, tbl[i].buz, tbl[i].mv, tbl[i].id, tbl[i].tm, tbl[i].cnt}));
    end
    takenPulse = 1'b0; secTick = 1'b0; missReady = 1'b0; pillDue = '0;

    // Missed pill 0 with a 4-cycle stall on the log port.
    autoTick = 1'b1;
    doReset();
    timeBCD = 24'h081500;
    cyc();
    pillDue = 3'b001;
    waitValid("bp_valid");
    check("bp_record", 64'({seqState, missPillId, missTime}), 64'({2'd2, 2'd0, 24'h081500}));
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("bp_stall", 64'({missValid, missPillId, missTime}), 64'({1'b1, 2'd0, 24'h081500}));
    end
    missReady = 1'b1;
    cyc();
    missReady = 1'b0;
    check("bp_done", 64'({missValid, seqState, missCounts}), 64'({1'b0, 2'd0, 12'h001}));
    pillDue = '0;

    // Simultaneous due on pills 2 and 0: logged lowest index first.
    doReset();
    missReady = 1'b1;
    pillDue = 3'b101;
    nRec = 0;
    for (int k = 0; k < 400 && nRec < 2; k++) begin
      cyc();
      if (missValid && missReady) begin
        ids[nRec] = missPillId;
        nRec++;
      end
    end
    cyc();
    check("sim_count", 64'(nRec), 64'd2);
    check("sim_order", 64'({ids[0], ids[1]}), 64'({2'd0, 2'd2}));
    check("sim_counters", 64'(missCounts), 64'h101);
    pillDue = '0;

    // Seventeen misses of pill 1: counter saturates at 4'hF.
    doReset();
    missReady = 1'b1;
    for (int m = 1; m <= 17; m++) begin
      pillDue = '0;
      cyc();
      cyc();
      pillDue = 3'b010;
      waitValid($sformatf("sat_valid%0d", m));
      cyc();
      if (m == 16) check("sat16", 64'(missCounts[7:4]), 64'hF);
      if (m == 17) check("sat17", 64'(missCounts), 64'h0F0);
    end
    pillDue = '0;

    // Reset asserted while a record is waiting.
    missReady = 1'b0;
    cyc();
    pillDue = 3'b001;
    waitValid("rst_valid");
    pillDue = '0;
    cyc();
    rst_n = 1'b0;
    #1;
    check("rst_midlog", 64'({missValid, seqState, missCounts}), 64'd0);
    cyc();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (seqState != 2'd0 || missValid || alarmLED != '0) bad = 1'b1;
    end
    check("rst_no_reraise", 64'(bad), 64'd0);

    // Taken in the same cycle as the expiring tick.
    missReady = 1'b1;
    pillDue = 3'b010;
    nTick = 0;
    for (int k = 0; k < 300; k++) begin
      cyc();
      takenPulse = 1'b0;
      if (seqState == 2'd1 && secTick) begin
        nTick++;
        if (nTick == GR) begin
          takenPulse = 1'b1;
          break;
        end
      end
    end
    check("coin_ticks", 64'(nTick), 64'(GR));
    cyc();
    takenPulse = 1'b0;
    check("coin_state", 64'({seqState, missValid, alarmLED}), 64'd0);
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (missValid) bad = 1'b1;
    end
    check("coin_nolog", 64'({bad, missCounts}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
`default_nettype wire
